// File: rtl/uart_pkg.sv
// Shared definitions for the UART baud/oversample tick generator:
// FSM state encoding and the legal OVERSAMPLE values.
package uart_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } baud_state_e;

  localparam int unsigned OS_LEGAL_8  = 8;
  localparam int unsigned OS_LEGAL_16 = 16;

  function automatic bit os_legal(input int unsigned os);
    return (os == OS_LEGAL_8) || (os == OS_LEGAL_16);
  endfunction

endpackage

// File: rtl/uart_baud_tick_gen.sv
// Oversample/baud tick generator with down-counter period and shadowed divisor.
// Define UART_BAUD_FRAC_EN to enable the fractional divisor accumulator.
module uart_baud_tick_gen
  import uart_pkg::*;
#(
  parameter int unsigned DIV_W      = 16,
  parameter int unsigned FRAC_W     = 4,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic [DIV_W-1:0]              div_int,
  input  logic [FRAC_W-1:0]             div_frac,
  input  logic                          div_load,
  output logic                          os_tick,
  output logic [$clog2(OVERSAMPLE)-1:0] os_index,
  output logic                          baud_tick,
  output logic                          active
);

  localparam int unsigned IDX_W = $clog2(OVERSAMPLE);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(OVERSAMPLE - 1);

  baud_state_e      state_q;
  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] sh_int_q;
  logic [DIV_W-1:0] sh_int_d;
  logic [DIV_W-1:0] eff_int;
  logic [DIV_W-1:0] reload_val;
  logic [IDX_W-1:0] idx_q;
  logic [IDX_W-1:0] idx_inc;
  logic             os_tick_q;
  logic             baud_tick_q;
  logic             active_q;

`ifdef UART_BAUD_FRAC_EN
  logic [FRAC_W-1:0] sh_frac_q;
  logic [FRAC_W-1:0] sh_frac_d;
  logic [FRAC_W-1:0] acc_q;
  logic [FRAC_W:0]   acc_sum;
`else
  logic unused_frac;
  assign unused_frac = ^div_frac;
`endif

  // A load in the same cycle as a reload must be seen by that reload, so
  // the reload path works from the next-state shadow value.
  always_comb begin
    sh_int_d = div_load ? div_int : sh_int_q;
    eff_int  = (sh_int_d < DIV_W'(2)) ? DIV_W'(2) : sh_int_d;
    idx_inc  = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
`ifdef UART_BAUD_FRAC_EN
    sh_frac_d  = div_load ? div_frac : sh_frac_q;
    acc_sum    = {1'b0, acc_q} + {1'b0, sh_frac_d};
    reload_val = acc_sum[FRAC_W] ? eff_int : eff_int - DIV_W'(1);
`else
    reload_val = eff_int - DIV_W'(1);
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      sh_int_q    <= '1;
      idx_q       <= '0;
      os_tick_q   <= 1'b0;
      baud_tick_q <= 1'b0;
      active_q    <= 1'b0;
`ifdef UART_BAUD_FRAC_EN
      sh_frac_q   <= '0;
      acc_q       <= '0;
`endif
    end else begin
      sh_int_q    <= sh_int_d;
`ifdef UART_BAUD_FRAC_EN
      sh_frac_q   <= sh_frac_d;
`endif
      os_tick_q   <= 1'b0;
      baud_tick_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          idx_q <= '0;
          if (en) begin
            state_q  <= ST_RUN;
            active_q <= 1'b1;
            cnt_q    <= eff_int - DIV_W'(1);
`ifdef UART_BAUD_FRAC_EN
            acc_q    <= '0;
`endif
          end else begin
            active_q <= 1'b0;
          end
        end
        ST_RUN: begin
          if (!en) begin
            // Abandon the current period outright: no tick even if due now.
            state_q  <= ST_IDLE;
            active_q <= 1'b0;
            cnt_q    <= '0;
            idx_q    <= '0;
          end else if (cnt_q == '0) begin
            os_tick_q   <= 1'b1;
            baud_tick_q <= (idx_q == IDX_LAST);
            idx_q       <= idx_inc;
            cnt_q       <= reload_val;
`ifdef UART_BAUD_FRAC_EN
            acc_q       <= acc_sum[FRAC_W-1:0];
`endif
          end else begin
            cnt_q <= cnt_q - DIV_W'(1);
          end
        end
        default: begin
          state_q  <= ST_IDLE;
          active_q <= 1'b0;
          cnt_q    <= '0;
          idx_q    <= '0;
        end
      endcase
    end
  end

  assign os_tick   = os_tick_q;
  assign os_index  = idx_q;
  assign baud_tick = baud_tick_q;
  assign active    = active_q;

endmodule

// File: tb/tb_uart_baud_tick_gen.sv
// Self-checking bench for uart_baud_tick_gen: directed scenarios plus random
// traffic, checked every cycle against a tick-time reference model.
module tb_uart_baud_tick_gen;

  localparam int unsigned DIV_W  = 16;
  localparam int unsigned FRAC_W = 4;
  localparam int unsigned OS     = 16;

  logic        clk = 1'b0;
  logic        rst, en, div_load;
  logic [15:0] div_int;
  logic [3:0]  div_frac;
  logic        os_tick, baud_tick, active;
  logic [3:0]  os_index;

  uart_baud_tick_gen #(.DIV_W(DIV_W), .FRAC_W(FRAC_W), .OVERSAMPLE(OS)) dut (
    .clk(clk), .rst(rst), .en(en), .div_int(div_int), .div_frac(div_frac),
    .div_load(div_load), .os_tick(os_tick), .os_index(os_index),
    .baud_tick(baud_tick), .active(active)
  );

  always #5 clk = ~clk;

  int unsigned checks = 0;
  int unsigned passed = 0;

  // Reference model: tracks the absolute cycle at which the next tick is due.
  int unsigned cyc = 0;
  bit          m_run = 0, m_tick = 0, m_baud = 0;
  int unsigned m_sh = 0, m_shf = 0, m_next = 0, m_acc = 0, m_idx = 0;
  int unsigned tick_log[$];
  int unsigned entry;

`ifdef UART_BAUD_FRAC_EN
  localparam int unsigned SPAN_4_8 = 72;
`else
  localparam int unsigned SPAN_4_8 = 64;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d cyc=%0d", tag, obs, exp, cyc);
  endtask

  task automatic model_edge();
    int unsigned nsh, nshf, eff, carry;
    cyc++;
    m_tick = 0;
    m_baud = 0;
    if (rst) begin
      m_run = 0; m_sh = 65535; m_shf = 0; m_idx = 0; m_acc = 0;
      return;
    end
    nsh  = div_load ? int'(div_int) : m_sh;
    nshf = div_load ? int'(div_frac) : m_shf;
    eff  = (nsh < 2) ? 2 : nsh;
    carry = 0;
    if (!m_run) begin
      if (en) begin
        m_run = 1; m_next = cyc + eff; m_acc = 0; m_idx = 0;
      end
    end else if (!en) begin
      m_run = 0; m_idx = 0;
    end else if (cyc == m_next) begin
      m_tick = 1;
      m_idx  = (m_idx + 1) % OS;
      m_baud = (m_idx == 0);
`ifdef UART_BAUD_FRAC_EN
      m_acc += nshf;
      carry  = (m_acc >= (1 << FRAC_W)) ? 1 : 0;
      m_acc  = m_acc % (1 << FRAC_W);
`endif
      m_next = cyc + eff + carry;
    end
    m_sh  = nsh;
    m_shf = nshf;
  endtask

  task automatic step(input bit r, input bit e, input bit ld, input int unsigned di,
                      input int unsigned df);
    rst = r; en = e; div_load = ld;
    div_int = di[15:0]; div_frac = df[3:0];
    @(posedge clk);
    model_edge();
    #1;
    chk("os_tick", os_tick, m_tick);
    chk("os_index", os_index, m_idx);
    chk("baud_tick", baud_tick, m_baud);
    chk("active", active, m_run);
    if (os_tick === 1'b1) tick_log.push_back(cyc);
  endtask

  task automatic run(input int unsigned n, input bit e);
    for (int unsigned i = 0; i < n; i++) step(0, e, 0, 0, 0);
  endtask

  initial begin
    bit r, e, ld;
    bit reached;

    repeat (3) step(1, 1, 1, 9, 9);

    // Integer divisor 4: first tick 4 clocks after entry, baud every 64
    step(0, 0, 1, 4, 0);
    tick_log.delete();
    entry = cyc + 1;
    run(140, 1);
    chk("tick_count_div4", tick_log.size() >= 17, 1);
    chk("first_tick_lat", tick_log[0] - entry, 4);
    chk("os_period_div4", tick_log[1] - tick_log[0], 4);
    chk("baud_span_div4", tick_log[16] - tick_log[0], 64);

    // Fractional 4 + 8/16
    run(2, 0);
    step(0, 0, 1, 4, 8);
    tick_log.delete();
    run(100, 1);
    chk("span16_frac", tick_log[16] - tick_log[0], SPAN_4_8);

    // Minimum period
    run(2, 0);
    step(0, 0, 1, 1, 0);
    tick_log.delete();
    run(20, 1);
    chk("period_div1", tick_log[1] - tick_log[0], 2);

    // Mid-period reload 4 -> 10
    run(2, 0);
    step(0, 0, 1, 4, 0);
    tick_log.delete();
    entry = cyc + 1;
    step(0, 1, 0, 0, 0);
    step(0, 1, 1, 10, 0);
    run(30, 1);
    chk("midload_first", tick_log[0] - entry, 4);
    chk("midload_next", tick_log[1] - tick_log[0], 10);

    // Reset at os_index 7
    run(2, 0);
    step(0, 0, 1, 3, 0);
    reached = 0;
    for (int unsigned i = 0; i < 200 && !reached; i++) begin
      step(0, 1, 0, 0, 0);
      if (m_idx == 7) reached = 1;
    end
    chk("reach_idx7", reached, 1);
    step(1, 1, 0, 0, 0);
    chk("rst_idx", os_index, 0);
    chk("rst_active", active, 0);
    step(0, 0, 1, 3, 0);
    run(40, 1);

    // en falls at os_index 5, with a load in the same cycle
    reached = 0;
    for (int unsigned i = 0; i < 200 && !reached; i++) begin
      step(0, 1, 0, 0, 0);
      if (m_idx == 5) reached = 1;
    end
    chk("reach_idx5", reached, 1);
    step(0, 0, 1, 6, 0);
    chk("enfall_tick", os_tick, 0);
    chk("enfall_idx", os_index, 0);
    tick_log.delete();
    entry = cyc + 1;
    run(20, 1);
    chk("enfall_load", tick_log[0] - entry, 6);

    // Random traffic
    for (int unsigned i = 0; i < 3000; i++) begin
      r  = ($urandom % 500) == 0;
      e  = ($urandom % 40) != 0;
      ld = ($urandom % 25) == 0;
      step(r, e, ld, $urandom_range(0, 12), $urandom);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/uart_baud_tick_gen.md
UART_BAUD_TICK_GEN -- requirements
Module: uart_baud_tick_gen

Interface
REQ-001 SHALL have parameter DIV_W, default 16: width of integer divisor.
REQ-002 SHALL have parameter FRAC_W, default 4: width of fractional divisor (units of 1/2^FRAC_W clock).
REQ-003 SHALL have parameter OVERSAMPLE, default 16: oversample ticks per bit; legal values 8 or 16.
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port en  input  1  level; 1 = generate ticks, 0 = idle.
REQ-007 SHALL have port div_int  input  DIV_W  integer clocks per oversample tick.
REQ-008 SHALL have port div_frac  input  FRAC_W  fractional clocks per oversample tick.
REQ-009 SHALL have port div_load  input  1  one-cycle strobe capturing div_int/div_frac into shadow registers.
REQ-010 SHALL have port os_tick  output  1  one-cycle pulse per oversample period.
REQ-011 SHALL have port os_index  output  log2(OVERSAMPLE)  oversample phase within bit.
REQ-012 SHALL have port baud_tick  output  1  one-cycle pulse per bit period.
REQ-013 SHALL have port active  output  1  1 while in RUN state.

Function
REQ-014 SHALL implement FSM states IDLE and RUN; IDLE->RUN when en=1, RUN->IDLE when en=0; transition visible next cycle.
REQ-015 SHALL on IDLE->RUN load down-counter with shadow_int-1, clear fractional accumulator, clear os_index.
REQ-016 SHALL in RUN decrement counter each cycle; at counter=0 assert os_tick for exactly one cycle (registered output).
REQ-017 SHALL on each os_tick add shadow_frac to FRAC_W-bit accumulator; on carry-out reload counter with shadow_int, else shadow_int-1 (mean period = div_int + div_frac/2^FRAC_W).
REQ-018 SHALL treat shadow_int values 0 and 1 as 2 (minimum period 2 clocks).
REQ-019 SHALL increment os_index on each os_tick, wrapping OVERSAMPLE-1 -> 0.
REQ-020 SHALL assert baud_tick in the same cycle as the os_tick on which os_index wraps to 0.
REQ-021 SHALL capture div_load into shadow registers in any state; in RUN the new value takes effect at the next counter reload only (no truncated/glitched period).
REQ-022 SHALL in IDLE hold os_tick=0, baud_tick=0, active=0, os_index=0.
REQ-023 SHALL when en falls mid-period abandon the period; no partial-period tick is emitted; div_load in that same cycle is still captured.
REQ-024 SHALL treat simultaneous div_load and counter reload as: reload uses the newly loaded value.

Reset
REQ-025 SHALL on rst=1 (sampled at clk) enter IDLE, clear counter, accumulator, os_index, os_tick, baud_tick, active.
REQ-026 SHALL reset shadow_int to all-ones and shadow_frac to 0; rst has priority over en and div_load.

Configuration
REQ-027 SHALL compile fractional support only when UART_BAUD_FRAC_EN is defined.
REQ-028 SHALL without UART_BAUD_FRAC_EN omit accumulator and shadow_frac, ignore div_frac, and reload always shadow_int-1 (integer divisor only); port list unchanged.

Structure
REQ-029 SHALL place FSM state encoding and legal OVERSAMPLE values in shared package uart_pkg.
REQ-030 SHALL be a single module; no sub-module required.

Verification
REQ-031 SHALL cover: OVERSAMPLE=16, div_int=4, div_frac=0, en=1 -> os_tick every 4 clocks, baud_tick every 64 clocks, first os_tick 4 clocks after RUN entry.
REQ-032 SHALL cover: FRAC_W=4, div_int=4, div_frac=8, macro defined -> periods alternate 4/5, 16 os_ticks span 72 clocks; macro undefined -> 64 clocks.
REQ-033 SHALL cover: div_int=1 -> os_tick every 2 clocks.
REQ-034 SHALL cover: div_load 4->10 mid-period -> current period completes at 4, next period is 10, no short pulse.
REQ-035 SHALL cover: rst=1 at os_index=7 -> next cycle all outputs 0, os_index=0; after release with en=1 sequence restarts from index 0.
REQ-036 SHALL cover: en deasserted at os_index=5 -> IDLE next cycle, no os_tick/baud_tick, os_index=0.
